// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the p18240 MMIO responder.
//   - Register offsets inside the 4-word I/O window.
//   - TX serializer state encoding.
//   - Bit positions inside the status word.
package mmio_responder_pkg;

    localparam logic [1:0] IO_SW_OFF   = 2'd0;
    localparam logic [1:0] IO_STAT_OFF = 2'd1;
    localparam logic [1:0] IO_DIV_OFF  = 2'd2;
    localparam logic [1:0] IO_CLR_OFF  = 2'd3;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_EMPTY_BIT = 1;
    localparam int unsigned STAT_FULL_BIT  = 2;
    localparam int unsigned STAT_OVF_BIT   = 3;

endpackage

// File: rtl/mmio_responder_tx_serializer.sv
// 8N1 serial transmitter FSM with a 16-bit bit-period counter.
// Accepts one byte from the FIFO via a valid/pop handshake; pop_o is high for
// exactly the cycle in which the byte is taken.
//   clk_i     input   1   clock
//   rst_i     input   1   synchronous active-high reset
//   div_i     input   16  current baud divisor (latched at frame start)
//   valid_i   input   1   FIFO non-empty
//   data_i    input   8   FIFO head byte
//   pop_o     output  1   byte accepted this cycle
//   txd_o     output  1   serial line, idle high
//   active_o  output  1   FSM is not in IDLE
module io_tx_serializer
    import mmio_responder_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] div_i,
    input  logic        valid_i,
    input  logic [7:0]  data_i,
    output logic        pop_o,
    output logic        txd_o,
    output logic        active_o
);

    tx_state_t   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] bit_div_q, bit_div_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            bit_div_q <= 16'd0;
            shift_q   <= 8'd0;
            idx_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_div_q <= bit_div_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
        end
    end

    // cnt counts down from bit_div to 0; reaching 0 marks the last clock of a bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_div_d = bit_div_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        pop_o     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    pop_o     = 1'b1;
                    bit_div_d = div_i;
                    cnt_d     = div_i;
                    shift_d   = data_i;
                    idx_d     = 3'd0;
                    state_d   = START;
                end
            end
            START: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = bit_div_q;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = bit_div_q;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == 16'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        txd_o = 1'b1;
        unique case (state_q)
            START:   txd_o = 1'b0;
            DATA:    txd_o = shift_q[0];
            default: txd_o = 1'b1;
        endcase
    end

    assign active_o = (state_q != IDLE);

endmodule

// File: rtl/tridrive.sv
// Tri-state bus driver: drives data_i onto bus_io while oe_i is high, else high-Z.
//   data_i  input  Width  value to drive
//   oe_i    input  1      output enable
//   bus_io  inout  Width  shared bus
module tridrive #(
    parameter int unsigned Width = 16
) (
    input  logic [Width-1:0] data_i,
    input  logic             oe_i,
    inout  wire  [Width-1:0] bus_io
);

    assign bus_io = oe_i ? data_i : {Width{1'bz}};

endmodule

// File: rtl/mmio_responder.sv
// p18240 memory-bus responder for a 4-word I/O window.
//   +0 R: synchronized switches   W: LED register
//   +1 R: status                  W: push byte into TX FIFO
//   +2 R: baud divisor            W: baud divisor
//   +3 R: 16'h0000                W: clear overflow
// Ports:
//   clock    input   1   system clock
//   reset    input   1   synchronous active-high reset
//   memAddr  input   16  bus address
//   re_L     input   1   active-low read enable
//   we_L     input   1   active-low write enable
//   dataBus  inout   16  shared data bus, driven only on a decoded read
//   SW       input   16  asynchronous switches
//   LEDR     output  16  LED register
//   txd      output  1   serial out, idle high
//   txBusy   output  1   frame on the wire or FIFO non-empty
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h2000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] memAddr,
    input  logic        re_L,
    input  logic        we_L,
    inout  wire  [15:0] dataBus,
    input  logic [15:0] SW,
    output logic [15:0] LEDR,
    output logic        txd,
    output logic        txBusy
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic        sel, rd_en, wr_en;
    logic [1:0]  offset;
    logic [15:0] rdata;

    logic [15:0] led_q, led_d;
    logic [15:0] div_q, div_d;
    logic        ovf_q, ovf_d;
    logic [15:0] sw_meta_q, sw_sync_q;

    logic [7:0]      fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            fifo_full, fifo_empty;
    logic            push_req, push_ok, pop;
    logic            tx_active;

    assign sel    = (memAddr[15:2] == BASE_ADDR[15:2]);
    assign offset = memAddr[1:0];
    assign rd_en  = sel & ~re_L;
    assign wr_en  = sel & ~we_L;

    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push_req   = wr_en & (offset == IO_STAT_OFF);
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign push_ok    = push_req & (~fifo_full | pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            led_q     <= 16'd0;
            div_q     <= DIV_RESET;
            ovf_q     <= 1'b0;
            sw_meta_q <= 16'd0;
            sw_sync_q <= 16'd0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
        end else begin
            led_q     <= led_d;
            div_q     <= div_d;
            ovf_q     <= ovf_d;
            sw_meta_q <= SW;
            sw_sync_q <= sw_meta_q;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
        end
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem_q[wptr_q] <= dataBus[7:0];
        end
    end

    always_comb begin
        led_d = led_q;
        div_d = div_q;
        ovf_d = ovf_q;
        if (wr_en) begin
            unique case (offset)
                IO_SW_OFF:   led_d = dataBus;
                IO_STAT_OFF: if (!push_ok) ovf_d = 1'b1;
                IO_DIV_OFF:  div_d = dataBus;
                IO_CLR_OFF:  ovf_d = 1'b0;
                default:     ;
            endcase
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    io_tx_serializer u_tx (
        .clk_i    (clock),
        .rst_i    (reset),
        .div_i    (div_q),
        .valid_i  (~fifo_empty),
        .data_i   (fifo_mem_q[rptr_q]),
        .pop_o    (pop),
        .txd_o    (txd),
        .active_o (tx_active)
    );

    assign txBusy = tx_active | ~fifo_empty;
    assign LEDR   = led_q;

    always_comb begin
        rdata = 16'h0000;
        unique case (offset)
            IO_SW_OFF: rdata = sw_sync_q;
            IO_STAT_OFF: begin
                rdata[STAT_OVF_BIT]   = ovf_q;
                rdata[STAT_FULL_BIT]  = fifo_full;
                rdata[STAT_EMPTY_BIT] = fifo_empty;
                rdata[STAT_BUSY_BIT]  = txBusy;
            end
            IO_DIV_OFF: rdata = div_q;
            IO_CLR_OFF: rdata = 16'h0000;
            default:    rdata = 16'h0000;
        endcase
    end

    tridrive #(
        .Width (16)
    ) u_drive (
        .data_i (rdata),
        .oe_i   (rd_en),
        .bus_io (dataBus)
    );

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed scenarios with literal
// expectations, then randomized bus traffic checked every cycle against a
// queue-based model of the register file, FIFO and serial waveform.
module tb_mmio_responder;

    localparam logic [15:0] Base     = 16'h2000;
    localparam int unsigned Depth    = 4;
    localparam logic [15:0] DivReset = 16'd433;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic [15:0] memAddr = 16'h0000;
    logic        re_L    = 1'b1;
    logic        we_L    = 1'b1;
    logic [15:0] SW      = 16'h0000;
    logic        tb_oe   = 1'b0;
    logic [15:0] tb_data = 16'h0000;
    tri1  [15:0] dataBus;
    logic [15:0] LEDR;
    logic        txd, txBusy;

    assign dataBus = tb_oe ? tb_data : 16'hzzzz;

    mmio_responder #(
        .BASE_ADDR  (Base),
        .FIFO_DEPTH (Depth),
        .DIV_RESET  (DivReset)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .memAddr (memAddr),
        .re_L    (re_L),
        .we_L    (we_L),
        .dataBus (dataBus),
        .SW      (SW),
        .LEDR    (LEDR),
        .txd     (txd),
        .txBusy  (txBusy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_led, m_div, m_meta, m_sync;
    logic        m_ovf;
    logic [7:0]  m_fifo[$];
    logic        m_wave[$];  // txd value for each upcoming cycle of the current frame

    function automatic logic m_busy();
        return (m_wave.size() != 0) || (m_fifo.size() != 0);
    endfunction

    function automatic logic [15:0] m_read(input logic [1:0] off);
        case (off)
            2'd0:    return m_sync;
            2'd1:    return {12'h000, m_ovf, m_fifo.size() == Depth, m_fifo.size() == 0, m_busy()};
            2'd2:    return m_div;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic m_frame(input logic [7:0] b, input logic [15:0] d);
        int n;
        n = int'(d) + 1;
        for (int k = 0; k < n; k++) m_wave.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < n; k++) m_wave.push_back(b[i]);
        for (int k = 0; k < n; k++) m_wave.push_back(1'b1);
    endtask

    initial begin : model
        logic       in_win;
        logic       idle_before;
        logic [7:0] b;
        forever begin
            @(posedge clock);
            if (reset) begin
                m_led = 16'h0000; m_div = DivReset; m_ovf = 1'b0;
                m_meta = 16'h0000; m_sync = 16'h0000;
                m_fifo.delete(); m_wave.delete();
            end else begin
                in_win      = (memAddr[15:2] == Base[15:2]);
                idle_before = (m_wave.size() == 0);
                if (!idle_before) void'(m_wave.pop_front());
                if (idle_before && m_fifo.size() != 0) begin
                    b = m_fifo.pop_front();
                    m_frame(b, m_div);
                end
                if (!we_L && in_win) begin
                    case (memAddr[1:0])
                        2'd0: m_led = tb_data;
                        2'd1: if (m_fifo.size() < Depth) m_fifo.push_back(tb_data[7:0]);
                              else m_ovf = 1'b1;
                        2'd2: m_div = tb_data;
                        default: m_ovf = 1'b0;
                    endcase
                end
                m_sync = m_meta;
                m_meta = SW;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin : compare
        logic [15:0] exp_bus;
        @(posedge clock);
        forever begin
            @(negedge clock);
            check("txd", txd, (m_wave.size() != 0) ? m_wave[0] : 1'b1);
            check("txBusy", txBusy, m_busy());
            check("LEDR", LEDR, m_led);
            if (!tb_oe) begin
                if (!re_L && memAddr[15:2] == Base[15:2]) exp_bus = m_read(memAddr[1:0]);
                else exp_bus = 16'hFFFF;
                check("dataBus", dataBus, exp_bus);
            end
        end
    end

    // Receiver for divisor-0 frames (one clock per bit).
    logic       rx_en = 1'b0;
    logic [7:0] rx_q[$];
    initial begin : rx
        logic [7:0] b;
        forever begin
            @(negedge clock);
            if (rx_en && txd == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clock);
                    b[i] = txd;
                end
                @(negedge clock);
                check("rx_stop_bit", txd, 1'b1);
                rx_q.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        memAddr = a; tb_data = d; tb_oe = 1'b1; we_L = 1'b0;
        cyc();
        we_L = 1'b1; tb_oe = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        memAddr = a; re_L = 1'b0;
        @(negedge clock);
        d = dataBus;
        cyc();
        re_L = 1'b1;
    endtask

    logic [15:0] rv;
    logic [7:0]  bytes_in [6];
    logic [7:0]  frame_byte;
    logic        exp_txd;
    int          found;

    initial begin : main
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state and switch synchronizer.
        check("reset_LEDR", LEDR, 16'h0000);
        check("reset_txd", txd, 1'b1);
        check("reset_txBusy", txBusy, 1'b0);
        SW = 16'hBEEF;
        repeat (3) cyc();
        rd(Base + 16'd0, rv);  check("read_sw", rv, 16'hBEEF);
        rd(Base + 16'd1, rv);  check("read_status_reset", rv, 16'h0002);
        rd(Base + 16'd2, rv);  check("read_div_reset", rv, DivReset);
        rd(Base + 16'd3, rv);  check("read_off3", rv, 16'h0000);
        @(negedge clock);
        check("bus_idle_highz", dataBus, 16'hFFFF);
        cyc();

        // LED write and out-of-window accesses.
        wr(Base + 16'd0, 16'h00F0);
        check("led_write", LEDR, 16'h00F0);
        wr(16'h2004, 16'h1234);
        check("led_outside_window", LEDR, 16'h00F0);
        rd(16'h2004, rv);  check("read_outside_window", rv, 16'hFFFF);

        // Divisor 3, byte A5: one pending cycle, then a 40-clock frame.
        wr(Base + 16'd2, 16'd3);
        frame_byte = 8'hA5;
        wr(Base + 16'd1, {8'h00, frame_byte});
        for (int c = 0; c < 42; c++) begin
            @(negedge clock);
            if (c >= 1 && c <= 4)       exp_txd = 1'b0;
            else if (c >= 5 && c <= 36) exp_txd = frame_byte[(c - 5) / 4];
            else                        exp_txd = 1'b1;
            check("a5_txd", txd, exp_txd);
            check("a5_txBusy", txBusy, (c <= 40) ? 1'b1 : 1'b0);
        end
        cyc();

        // Divisor 0, six back-to-back pushes: one popped, four queued, one dropped.
        wr(Base + 16'd2, 16'd0);
        rx_en = 1'b1;
        bytes_in[0] = 8'h11; bytes_in[1] = 8'h22; bytes_in[2] = 8'h33;
        bytes_in[3] = 8'h44; bytes_in[4] = 8'h55; bytes_in[5] = 8'h66;
        for (int i = 0; i < 6; i++) wr(Base + 16'd1, {8'h00, bytes_in[i]});
        rd(Base + 16'd1, rv);  check("status_overflow", rv, 16'h000D);
        wr(Base + 16'd3, 16'h0000);
        rd(Base + 16'd1, rv);  check("overflow_cleared", rv[3], 1'b0);

        // Push on the very edge the serializer pops from a full FIFO.
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (m_wave.size() == 0 && m_fifo.size() == Depth) found = 1;
            else cyc();
        end
        check("pop_window_found", found, 1);
        wr(Base + 16'd1, 16'h0077);
        rd(Base + 16'd1, rv);  check("status_push_pop_full", rv, 16'h0005);
        for (int i = 0; i < 300 && txBusy; i++) cyc();
        check("drain_done", txBusy, 1'b0);
        cyc();
        rx_en = 1'b0;
        check("rx_count", rx_q.size(), 6);
        if (rx_q.size() == 6) begin
            check("rx_byte0", rx_q[0], 8'h11);
            check("rx_byte1", rx_q[1], 8'h22);
            check("rx_byte2", rx_q[2], 8'h33);
            check("rx_byte3", rx_q[3], 8'h44);
            check("rx_byte4", rx_q[4], 8'h55);
            check("rx_byte5", rx_q[5], 8'h77);
        end

        // Reset in the middle of data bit 3.
        wr(Base + 16'd2, 16'd3);
        wr(Base + 16'd1, 16'h00C3);
        repeat (18) cyc();
        check("midframe_busy", txBusy, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst_txd", txd, 1'b1);
        check("rst_txBusy", txBusy, 1'b0);
        check("rst_LEDR", LEDR, 16'h0000);
        rd(Base + 16'd2, rv);  check("rst_div", rv, DivReset);
        rd(Base + 16'd1, rv);  check("rst_status", rv, 16'h0002);

        // Randomized traffic; the compare process checks every cycle.
        wr(Base + 16'd2, 16'd1);
        for (int n = 0; n < 4000; n++) begin
            int          r;
            logic [1:0]  off;
            logic [15:0] a;
            r   = $urandom_range(0, 999);
            off = 2'($urandom_range(0, 3));
            a   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : (Base | {14'h0, off});
            if ($urandom_range(0, 19) == 0) SW = 16'($urandom);
            if (r < 300) begin
                memAddr = a; re_L = 1'b0;
                cyc();
                re_L = 1'b1;
            end else if (r < 600) begin
                if (a[1:0] == 2'd2) wr(a, 16'($urandom_range(0, 2)));
                else wr(a, 16'($urandom));
            end else if (r < 602) begin
                reset = 1'b1;
                cyc();
                reset = 1'b0;
            end else begin
                cyc();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
